// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg -- generic MIPS32 pipeline-stage register
//
// This stage holds one payload beat between two pipeline stages and passes
// it on with a valid/ready handshake. It also supports FLUSH (discard) and
// FREEZE (hold) hazard controls.
//
// With SKID=1 the stage has a main entry and a skid entry. It sustains one
// beat per cycle, and IN_READY depends only on registered state, FREEZE,
// FLUSH and RESET. With SKID=0 the stage has a single entry, and IN_READY
// also depends combinationally on OUT_READY.
//
// Optional feature macro: PIPE_REG_STALL_CNT_EN
//   When defined, the STALL_CNT port and its saturating stall counter exist.
//
// Parameters
//   DATA_W       payload width
//   SKID         1 = main + skid entries, 0 = single entry
//   BUBBLE_DATA  payload loaded on reset/flush and driven while empty
//   CNT_W        stall-counter width (PIPE_REG_STALL_CNT_EN only)
//
// Ports
//   CLK        in   rising-edge clock
//   RESET      in   synchronous active-high reset
//   FLUSH      in   discard all held entries
//   FREEZE     in   hold contents, block accept and emit
//   IN_VALID   in   upstream beat valid
//   IN_READY   out  stage can accept this cycle
//   IN_DATA    in   upstream payload
//   OUT_VALID  out  downstream beat valid
//   OUT_READY  in   downstream accepts
//   OUT_DATA   out  payload, BUBBLE_DATA when empty
//   OCC        out  number of entries held (0..2)
//   STALL_CNT  out  saturating stall-cycle count (macro only)
// ---------------------------------------------------------------------------

// Structural sanity checks on the handshake outputs; never synthesised logic.
module pipe_stage_reg_chk #(
  parameter int unsigned SKID = 1
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  input logic       freeze,
  input logic       in_ready,
  input logic       out_valid,
  input logic [1:0] occ
);

  a_ready_blocked : assert property (@(posedge clk) disable iff (rst)
    in_ready |-> (!freeze && !flush));

  a_occ_range : assert property (@(posedge clk) disable iff (rst)
    occ <= ((SKID != 0) ? 2'd2 : 2'd1));

  a_valid_has_entry : assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (occ != 2'd0));

endmodule

module pipe_stage_reg #(
  parameter int unsigned        DATA_W      = 64,
  parameter int unsigned        SKID        = 1,
  parameter logic [DATA_W-1:0]  BUBBLE_DATA = {DATA_W{1'b0}},
  parameter int unsigned        CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              FREEZE,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCC
`ifdef PIPE_REG_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  STALL_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_n;
  logic [DATA_W-1:0] m_data_r;
  logic [DATA_W-1:0] s_data_s;
  logic              m_valid_s;
  logic              s_valid_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              m_load_in_s;
  logic              m_load_skid_s;
  logic              s_load_in_s;
  logic              clear_s;

  assign m_valid_s = (state_r == ST_ONE) || (state_r == ST_TWO);

  // In skid mode, readiness looks only at the skid entry. This keeps
  // OUT_READY off the IN_READY path. The single-entry mode instead accepts
  // whenever the held beat leaves this cycle.
  assign in_ready_s = ~RESET & ~FREEZE & ~FLUSH &
                      ((SKID != 0) ? ~s_valid_s : (~m_valid_s | OUT_READY));
  assign out_valid_s = m_valid_s & ~FREEZE & ~RESET;
  assign in_fire_s   = IN_VALID & in_ready_s;
  assign out_fire_s  = out_valid_s & OUT_READY;

  assign IN_READY  = in_ready_s;
  assign OUT_VALID = out_valid_s;
  assign OUT_DATA  = m_valid_s ? m_data_r : BUBBLE_DATA;

  // Occupancy report, forced to zero while reset is asserted.
  always_comb begin
    OCC = 2'd0;
    if (RESET) begin
      OCC = 2'd0;
    end else begin
      case (state_r)
        ST_EMPTY: OCC = 2'd0;
        ST_ONE:   OCC = 2'd1;
        ST_TWO:   OCC = 2'd2;
        default:  OCC = 2'd0;
      endcase
    end
  end

  // Next-state and data-steering decode; FLUSH outranks FREEZE and handshakes.
  always_comb begin
    state_n       = state_r;
    m_load_in_s   = 1'b0;
    m_load_skid_s = 1'b0;
    s_load_in_s   = 1'b0;
    clear_s       = 1'b0;
    if (FLUSH) begin
      state_n = ST_EMPTY;
      clear_s = 1'b1;
    end else if (FREEZE) begin
      state_n = state_r;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_n     = ST_ONE;
            m_load_in_s = 1'b1;
          end else begin
            state_n = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_n     = ST_ONE;
            m_load_in_s = 1'b1;
          end else if (in_fire_s) begin
            // Only reachable with a skid entry: single-entry mode accepts
            // into an occupied stage only when the held beat is leaving.
            if (SKID != 0) begin
              state_n     = ST_TWO;
              s_load_in_s = 1'b1;
            end else begin
              state_n = ST_ONE;
            end
          end else if (out_fire_s) begin
            state_n = ST_EMPTY;
          end else begin
            state_n = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_n       = ST_ONE;
            m_load_skid_s = 1'b1;
          end else begin
            state_n = ST_TWO;
          end
        end
        default: begin
          state_n = ST_EMPTY;
          clear_s = 1'b1;
        end
      endcase
    end
  end

  // State register with synchronous reset to EMPTY.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_n;
    end
  end

  // Main entry: the beat currently presented downstream.
  always_ff @(posedge CLK) begin
    if (RESET || clear_s) begin
      m_data_r <= BUBBLE_DATA;
    end else if (m_load_in_s) begin
      m_data_r <= IN_DATA;
    end else if (m_load_skid_s) begin
      m_data_r <= s_data_s;
    end else begin
      m_data_r <= m_data_r;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] s_data_r;

      // Skid entry: catches the beat accepted while the main entry is stuck.
      always_ff @(posedge CLK) begin
        if (RESET || clear_s) begin
          s_data_r <= BUBBLE_DATA;
        end else if (s_load_in_s) begin
          s_data_r <= IN_DATA;
        end else begin
          s_data_r <= s_data_r;
        end
      end

      assign s_data_s  = s_data_r;
      assign s_valid_s = (state_r == ST_TWO);
    end else begin : g_no_skid
      assign s_data_s  = BUBBLE_DATA;
      assign s_valid_s = 1'b0;
    end
  endgenerate

`ifdef PIPE_REG_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic             stall_s;

  // A held beat that cannot leave, either because of a hazard freeze or
  // because of downstream back-pressure, counts as a stall.
  assign stall_s = m_valid_s & (FREEZE | ~OUT_READY) & ~FLUSH;

  // Saturating stall counter; only RESET clears it, FLUSH does not.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign STALL_CNT = RESET ? {CNT_W{1'b0}} : stall_cnt_r;
`else
`endif

  pipe_stage_reg_chk #(
    .SKID (SKID)
  ) u_chk (
    .clk       (CLK),
    .rst       (RESET),
    .flush     (FLUSH),
    .freeze    (FREEZE),
    .in_ready  (in_ready_s),
    .out_valid (out_valid_s),
    .occ       (OCC)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [7:0] BUB = 8'hEE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       freeze = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;

  logic       in_ready1, out_valid1, in_ready0, out_valid0;
  logic [7:0] out_data1, out_data0;
  logic [1:0] occ1, occ0;
`ifdef PIPE_REG_STALL_CNT_EN
  logic [15:0] stall_cnt1;
  logic [1:0]  stall_cnt0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .BUBBLE_DATA(BUB), .CNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .FREEZE(freeze),
    .IN_VALID(in_valid), .IN_READY(in_ready1), .IN_DATA(in_data),
    .OUT_VALID(out_valid1), .OUT_READY(out_ready), .OUT_DATA(out_data1),
    .OCC(occ1)
`ifdef PIPE_REG_STALL_CNT_EN
    , .STALL_CNT(stall_cnt1)
`endif
  );

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .BUBBLE_DATA(BUB), .CNT_W(2)) dut0 (
    .CLK(clk), .RESET(rst), .FLUSH(flush), .FREEZE(freeze),
    .IN_VALID(in_valid), .IN_READY(in_ready0), .IN_DATA(in_data),
    .OUT_VALID(out_valid0), .OUT_READY(out_ready), .OUT_DATA(out_data0),
    .OCC(occ0)
`ifdef PIPE_REG_STALL_CNT_EN
    , .STALL_CNT(stall_cnt0)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid1); end
      n_vec++; if (in_ready1 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready1); end
      n_vec++; if (occ1 !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occ1); end
      n_vec++; if (out_data1 !== BUB) begin n_err++; $display("FAIL reset_out_data: got %h want %h", out_data1, BUB); end
      n_vec++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_skid0: got %b want 0", in_ready0); end
`ifdef PIPE_REG_STALL_CNT_EN
      n_vec++; if (stall_cnt0 !== 2'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt0); end
`endif
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready1); end
    n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid1); end
  endtask

  task automatic test_stream();
    logic [7:0] beats [4];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    cyc();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = beats[k];
      #1;
      n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", k, in_ready1); end
      n_vec++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL stream_in_ready_skid0[%0d]: got %b want 1", k, in_ready0); end
      if (k == 0) begin
        n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL stream_first_valid: got %b want 0", out_valid1); end
      end else begin
        n_vec++; if (out_valid1 !== 1'b1 || out_data1 !== beats[k-1]) begin n_err++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid1, out_data1, beats[k-1]); end
        n_vec++; if (out_valid0 !== 1'b1 || out_data0 !== beats[k-1]) begin n_err++; $display("FAIL stream_out_skid0[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid0, out_data0, beats[k-1]); end
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h44) begin n_err++; $display("FAIL stream_last: got v=%b d=%h want v=1 d=44", out_valid1, out_data1); end
    cyc();
    n_vec++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0 || out_data1 !== BUB) begin n_err++; $display("FAIL stream_drained: got v=%b occ=%0d d=%h want v=0 occ=0 d=%h", out_valid1, occ1, out_data1, BUB); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA1;
    #1;
    n_vec++; if (in_ready1 !== 1'b1 || occ1 !== 2'd0) begin n_err++; $display("FAIL skid_accept_a: got rdy=%b occ=%0d want rdy=1 occ=0", in_ready1, occ1); end
    cyc();
    in_data = 8'hB2;
    #1;
    n_vec++; if (in_ready1 !== 1'b1 || occ1 !== 2'd1 || out_data1 !== 8'hA1) begin n_err++; $display("FAIL skid_accept_b: got rdy=%b occ=%0d d=%h want rdy=1 occ=1 d=a1", in_ready1, occ1, out_data1); end
    cyc();
    in_data = 8'hC3;
    #1;
    n_vec++; if (in_ready1 !== 1'b0 || occ1 !== 2'd2 || out_data1 !== 8'hA1) begin n_err++; $display("FAIL skid_full: got rdy=%b occ=%0d d=%h want rdy=0 occ=2 d=a1", in_ready1, occ1, out_data1); end
    cyc();
    n_vec++; if (in_ready1 !== 1'b0 || occ1 !== 2'd2) begin n_err++; $display("FAIL skid_hold_c: got rdy=%b occ=%0d want rdy=0 occ=2", in_ready1, occ1); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (out_valid1 !== 1'b1 || out_data1 !== 8'hA1 || in_ready1 !== 1'b0) begin n_err++; $display("FAIL skid_emit_a: got v=%b d=%h rdy=%b want v=1 d=a1 rdy=0", out_valid1, out_data1, in_ready1); end
    cyc();
    n_vec++; if (out_valid1 !== 1'b1 || out_data1 !== 8'hB2 || in_ready1 !== 1'b1) begin n_err++; $display("FAIL skid_emit_b: got v=%b d=%h rdy=%b want v=1 d=b2 rdy=1", out_valid1, out_data1, in_ready1); end
    cyc();
    in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid1 !== 1'b1 || out_data1 !== 8'hC3) begin n_err++; $display("FAIL skid_emit_c: got v=%b d=%h want v=1 d=c3", out_valid1, out_data1); end
    cyc();
    n_vec++; if (occ1 !== 2'd0 || out_valid1 !== 1'b0) begin n_err++; $display("FAIL skid_drained: got occ=%0d v=%b want occ=0 v=0", occ1, out_valid1); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hD1;
    cyc();
    in_data = 8'hD2;
    cyc();
    in_data = 8'hD3; flush = 1'b1;
    #1;
    n_vec++; if (in_ready1 !== 1'b0 || occ1 !== 2'd2) begin n_err++; $display("FAIL flush_cycle: got rdy=%b occ=%0d want rdy=0 occ=2", in_ready1, occ1); end
    cyc();
    flush = 1'b0; in_data = 8'hD4;
    #1;
    n_vec++; if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_data1 !== BUB) begin n_err++; $display("FAIL flush_empty: got occ=%0d v=%b d=%h want occ=0 v=0 d=%h", occ1, out_valid1, out_data1, BUB); end
    n_vec++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL flush_ready_after: got %b want 1", in_ready1); end
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++; if (out_valid1 !== 1'b1 || out_data1 !== 8'hD4 || occ1 !== 2'd1) begin n_err++; $display("FAIL flush_new_beat: got v=%b d=%h occ=%0d want v=1 d=d4 occ=1", out_valid1, out_data1, occ1); end
    cyc();
    n_vec++; if (occ1 !== 2'd0) begin n_err++; $display("FAIL flush_new_drained: got occ=%0d want 0", occ1); end
  endtask

  task automatic test_freeze();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hF1;
    cyc();
    in_data = 8'h99; out_ready = 1'b1; freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0 || out_data1 !== 8'hF1 || occ1 !== 2'd1) begin n_err++; $display("FAIL freeze_hold[%0d]: got v=%b rdy=%b d=%h occ=%0d want v=0 rdy=0 d=f1 occ=1", i, out_valid1, in_ready1, out_data1, occ1); end
      cyc();
    end
    freeze = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (out_valid1 !== 1'b1 || out_data1 !== 8'hF1) begin n_err++; $display("FAIL freeze_release: got v=%b d=%h want v=1 d=f1", out_valid1, out_data1); end
    cyc();
    n_vec++; if (out_valid1 !== 1'b0 || occ1 !== 2'd0) begin n_err++; $display("FAIL freeze_once: got v=%b occ=%0d want v=0 occ=0", out_valid1, occ1); end
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hF2;
    cyc();
    in_valid = 1'b0; freeze = 1'b1; flush = 1'b1;
    #1;
    n_vec++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b0) begin n_err++; $display("FAIL freeze_flush_cycle: got v=%b rdy=%b want 0 0", out_valid1, in_ready1); end
    cyc();
    freeze = 1'b0; flush = 1'b0;
    #1;
    n_vec++; if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_data1 !== BUB) begin n_err++; $display("FAIL freeze_flush_result: got occ=%0d v=%b d=%h want occ=0 v=0 d=%h", occ1, out_valid1, out_data1, BUB); end
  endtask

  task automatic test_skid0();
    rst = 1'b1;
    cyc();
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    #1;
    n_vec++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL skid0_empty_ready: got %b want 1", in_ready0); end
    cyc();
    in_valid = 1'b0;
    #1;
    n_vec++; if (in_ready0 !== 1'b0 || occ0 !== 2'd1 || out_valid0 !== 1'b1 || out_data0 !== 8'h5A) begin n_err++; $display("FAIL skid0_blocked: got rdy=%b occ=%0d v=%b d=%h want rdy=0 occ=1 v=1 d=5a", in_ready0, occ0, out_valid0, out_data0); end
`ifdef PIPE_REG_STALL_CNT_EN
    n_vec++; if (stall_cnt0 !== 2'd0) begin n_err++; $display("FAIL stall_start: got %0d want 0", stall_cnt0); end
`endif
    cyc();
`ifdef PIPE_REG_STALL_CNT_EN
    n_vec++; if (stall_cnt0 !== 2'd1) begin n_err++; $display("FAIL stall_one: got %0d want 1", stall_cnt0); end
`endif
    for (int i = 0; i < 9; i++) cyc();
`ifdef PIPE_REG_STALL_CNT_EN
    n_vec++; if (stall_cnt0 !== 2'd3) begin n_err++; $display("FAIL stall_saturate: got %0d want 3", stall_cnt0); end
`endif
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    n_vec++; if (occ0 !== 2'd0 || out_valid0 !== 1'b0) begin n_err++; $display("FAIL skid0_flush: got occ=%0d v=%b want occ=0 v=0", occ0, out_valid0); end
`ifdef PIPE_REG_STALL_CNT_EN
    n_vec++; if (stall_cnt0 !== 2'd3) begin n_err++; $display("FAIL stall_after_flush: got %0d want 3", stall_cnt0); end
`endif
    in_valid = 1'b1; in_data = 8'h6B;
    cyc();
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_vec++; if (in_ready0 !== 1'b1 || out_data0 !== 8'h6B) begin n_err++; $display("FAIL skid0_pass_ready: got rdy=%b d=%h want rdy=1 d=6b", in_ready0, out_data0); end
    cyc();
    n_vec++; if (occ0 !== 2'd0) begin n_err++; $display("FAIL skid0_drained: got occ=%0d want 0", occ0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_freeze();
    test_skid0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
